// File: rtl/ntt_pkg.sv
// Shared types and modular helpers for the NTT butterfly datapath.
// Helpers operate on MAX_W-bit words; callers zero-extend and truncate.
package ntt_pkg;

    localparam int unsigned MAX_W = 64;

    typedef logic [MAX_W-1:0] word_t;

    typedef enum logic {
        BF_CT = 1'b0,
        BF_GS = 1'b1
    } bf_mode_t;

    function automatic int unsigned bf_latency(input int unsigned w, input int unsigned m_bits);
        return w / m_bits + 2;
    endfunction

    function automatic word_t mod_add(input word_t p, input word_t q, input word_t m);
        logic [MAX_W:0] s;
        s = {1'b0, p} + {1'b0, q};
        if (s >= {1'b0, m}) begin
            s = s - {1'b0, m};
        end
        return s[MAX_W-1:0];
    endfunction

    function automatic word_t mod_sub(input word_t p, input word_t q, input word_t m);
        logic [MAX_W:0] d;
        if (p >= q) begin
            d = {1'b0, p} - {1'b0, q};
        end else begin
            d = {1'b0, p} - {1'b0, q} + {1'b0, m};
        end
        return d[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/mod_addsub.sv
// Combinational modular add and subtract of two residues < m.
module mod_addsub
    import ntt_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] p,
    input  logic [W-1:0] q,
    input  logic [W-1:0] m,
    output logic [W-1:0] sum,
    output logic [W-1:0] diff
);

    assign sum  = W'(mod_add(MAX_W'(p), MAX_W'(q), MAX_W'(m)));
    assign diff = W'(mod_sub(MAX_W'(p), MAX_W'(q), MAX_W'(m)));

endmodule

// File: rtl/mont_mul.sv
// Digit-serial pipelined Montgomery multiplier: P = A*B*2^-W mod M after W/M_BITS cycles.
// Requires A, B < M < 2^(W-2); enable high freezes every stage.
module mont_mul #(
    parameter int unsigned W      = 32,
    parameter int unsigned M_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [W-1:0]      A,
    input  logic [W-1:0]      B,
    input  logic [W-1:0]      M,
    input  logic [M_BITS-1:0] M_inv,
    output logic [W-1:0]      P
);

    localparam int unsigned N  = W / M_BITS;
    localparam int unsigned TW = W + M_BITS + 2;

    logic [W-1:0] t_pipe [1:N];
    logic [W-1:0] a_pipe [1:N-1];
    logic [W-1:0] b_pipe [1:N-1];

    for (genvar i = 0; i < N; i++) begin : g_stage
        logic [W-1:0]      t_in;
        logic [W-1:0]      b_in;
        logic [M_BITS-1:0] digit;
        logic [M_BITS-1:0] qd;
        logic [TW-1:0]     s0;
        logic [TW-1:0]     s1;

        if (i == 0) begin : g_first
            assign t_in  = '0;
            assign digit = A[M_BITS-1:0];
            assign b_in  = B;
            if (N > 1) begin : g_fwd
                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_pipe[1] <= '0;
                        b_pipe[1] <= '0;
                    end else if (!enable) begin
                        a_pipe[1] <= A >> M_BITS;
                        b_pipe[1] <= B;
                    end
                end
            end
        end else begin : g_rest
            assign t_in  = t_pipe[i];
            assign digit = a_pipe[i][M_BITS-1:0];
            assign b_in  = b_pipe[i];
            if (i < N - 1) begin : g_fwd
                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_pipe[i+1] <= '0;
                        b_pipe[i+1] <= '0;
                    end else if (!enable) begin
                        a_pipe[i+1] <= a_pipe[i] >> M_BITS;
                        b_pipe[i+1] <= b_pipe[i];
                    end
                end
            end
        end

        // qd makes the low digit vanish so the shift is an exact division; t stays < 2M.
        always_comb begin
            s0 = TW'(t_in) + TW'(digit) * TW'(b_in);
            qd = s0[M_BITS-1:0] * M_inv;
            s1 = s0 + TW'(qd) * TW'(M);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                t_pipe[i+1] <= '0;
            end else if (!enable) begin
                t_pipe[i+1] <= W'(s1 >> M_BITS);
            end
        end
    end

    assign P = (t_pipe[N] >= M) ? t_pipe[N] - M : t_pipe[N];

endmodule

// File: rtl/ntt_butterfly.sv
// Pipelined CT/GS NTT butterfly around mont_mul; latency W/M_BITS+2, one butterfly per cycle.
module ntt_butterfly
    import ntt_pkg::*;
#(
    parameter int unsigned W      = 32,
    parameter int unsigned M_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              mode,
    input  logic [W-1:0]      u,
    input  logic [W-1:0]      v,
    input  logic [W-1:0]      w,
    input  logic [W-1:0]      M,
    input  logic [M_BITS-1:0] M_inv,
    output logic              out_valid,
    output logic              out_mode,
    output logic [W-1:0]      x,
    output logic [W-1:0]      y
);

    localparam int unsigned N = bf_latency(W, M_BITS) - 2;

    logic [W-1:0] pre_sum, pre_diff, post_sum, post_diff, t;
    logic [W-1:0] a_q, b_q, byp_q;
    logic         pv_q;
    bf_mode_t     pm_q;
    logic [W-1:0] byp_dly  [1:N];
    logic         vld_dly  [1:N];
    bf_mode_t     mode_dly [1:N];

    mod_addsub #(.W(W)) u_pre (
        .p    (u),
        .q    (v),
        .m    (M),
        .sum  (pre_sum),
        .diff (pre_diff)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            byp_q <= '0;
            pv_q  <= 1'b0;
            pm_q  <= BF_CT;
        end else begin
            a_q   <= (mode == BF_GS) ? pre_diff : v;
            b_q   <= w;
            byp_q <= (mode == BF_GS) ? pre_sum : u;
            pv_q  <= in_valid;
            pm_q  <= bf_mode_t'(mode);
        end
    end

    mont_mul #(.W(W), .M_BITS(M_BITS)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .enable (1'b0),
        .A      (a_q),
        .B      (b_q),
        .M      (M),
        .M_inv  (M_inv),
        .P      (t)
    );

    // Bypass operand and control ride alongside the multiplier stages.
    for (genvar i = 1; i <= N; i++) begin : g_dly
        if (i == 1) begin : g_head
            always_ff @(posedge clk) begin
                if (rst) begin
                    byp_dly[1]  <= '0;
                    vld_dly[1]  <= 1'b0;
                    mode_dly[1] <= BF_CT;
                end else begin
                    byp_dly[1]  <= byp_q;
                    vld_dly[1]  <= pv_q;
                    mode_dly[1] <= pm_q;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (rst) begin
                    byp_dly[i]  <= '0;
                    vld_dly[i]  <= 1'b0;
                    mode_dly[i] <= BF_CT;
                end else begin
                    byp_dly[i]  <= byp_dly[i-1];
                    vld_dly[i]  <= vld_dly[i-1];
                    mode_dly[i] <= mode_dly[i-1];
                end
            end
        end
    end

    mod_addsub #(.W(W)) u_post (
        .p    (byp_dly[N]),
        .q    (t),
        .m    (M),
        .sum  (post_sum),
        .diff (post_diff)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            x         <= '0;
            y         <= '0;
        end else begin
            out_valid <= vld_dly[N];
            out_mode  <= mode_dly[N];
            x         <= (mode_dly[N] == BF_CT) ? post_sum : byp_dly[N];
            y         <= (mode_dly[N] == BF_CT) ? post_diff : t;
        end
    end

endmodule

// File: tb/tb_ntt_butterfly.sv
// Randomized and directed bench for ntt_butterfly against a plain-arithmetic butterfly model.
module tb_ntt_butterfly;

    localparam int L = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, mode;
    logic [31:0] u, v, w, M;
    logic [7:0]  M_inv;
    logic        out_valid, out_mode;
    logic [31:0] x, y;

    always #5 clk = ~clk;

    ntt_butterfly dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .mode      (mode),
        .u         (u),
        .v         (v),
        .w         (w),
        .M         (M),
        .M_inv     (M_inv),
        .out_valid (out_valid),
        .out_mode  (out_mode),
        .x         (x),
        .y         (y)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Literal expectations travel with the stimulus for the directed vectors.
    bit     lit_en;
    longint lit_x, lit_y;

    bit     exp_v   [int];
    longint exp_x   [int];
    longint exp_y   [int];
    bit     exp_m   [int];
    bit     exp_lit [int];
    longint exp_lx  [int];
    longint exp_ly  [int];
    bit     rst_slot[int];

    function automatic longint inv_mod(input longint a, input longint m);
        longint r0, r1, t0, t1, q, tmp;
        r0 = m; r1 = a % m; t0 = 0; t1 = 1;
        while (r1 != 0) begin
            q = r0 / r1;
            tmp = r0 - q * r1; r0 = r1; r1 = tmp;
            tmp = t0 - q * t1; t0 = t1; t1 = tmp;
        end
        if (t0 < 0) t0 += m;
        return t0;
    endfunction

    // a*b*2^-32 mod m
    function automatic longint mont(input longint a, input longint b, input longint m);
        longint rinv;
        rinv = inv_mod((longint'(1) << 32) % m, m);
        return (((a * b) % m) * rinv) % m;
    endfunction

    function automatic logic [7:0] neg_inv8(input longint m);
        for (int k = 0; k < 256; k++) begin
            if (((m * k) & 255) == 255) return 8'(k);
        end
        return 8'd0;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    longint mu, mv, mw, mm, mt, mx, my;

    // Model: schedule the expected result for the output cycle of every accepted butterfly.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            rst_slot[cyc] = 1'b1;
            exp_v.delete(); exp_x.delete(); exp_y.delete(); exp_m.delete();
            exp_lit.delete(); exp_lx.delete(); exp_ly.delete();
        end else if (in_valid) begin
            assert (u < M && v < M && w < M) else $error("illegal operand >= M");
            mu = longint'(u); mv = longint'(v); mw = longint'(w); mm = longint'(M);
            if (mode == 1'b0) begin
                mt = mont(mv, mw, mm);
                mx = (mu + mt) % mm;
                my = (mu + mm - mt) % mm;
            end else begin
                mt = mont((mu + mm - mv) % mm, mw, mm);
                mx = (mu + mv) % mm;
                my = mt;
            end
            exp_v[cyc+L-1]   = 1'b1;
            exp_x[cyc+L-1]   = mx;
            exp_y[cyc+L-1]   = my;
            exp_m[cyc+L-1]   = mode;
            exp_lit[cyc+L-1] = lit_en;
            exp_lx[cyc+L-1]  = lit_x;
            exp_ly[cyc+L-1]  = lit_y;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst_slot.exists(cyc)) begin
                chk("rst_valid", longint'(out_valid), 0);
                chk("rst_mode", longint'(out_mode), 0);
                chk("rst_x", longint'(x), 0);
                chk("rst_y", longint'(y), 0);
            end else begin
                chk("out_valid", longint'(out_valid), longint'(exp_v.exists(cyc)));
                if (exp_v.exists(cyc)) begin
                    chk("x", longint'(x), exp_x[cyc]);
                    chk("y", longint'(y), exp_y[cyc]);
                    chk("out_mode", longint'(out_mode), longint'(exp_m[cyc]));
                    if (exp_lit[cyc]) begin
                        chk("x_literal", longint'(x), exp_lx[cyc]);
                        chk("y_literal", longint'(y), exp_ly[cyc]);
                    end
                end
            end
        end
    end

    task automatic drive(input bit vld, input bit md, input int uu, input int vv, input int ww,
                         input bit le, input longint lx, input longint ly);
        @(negedge clk);
        in_valid = vld; mode = md;
        u = 32'(uu); v = 32'(vv); w = 32'(ww);
        lit_en = le; lit_x = lx; lit_y = ly;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0);
    endtask

    // Directed vectors for M=17: mode, u, v, w, x, y
    int tv_md[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int tv_u [8] = '{5, 10, 1, 3, 16, 10, 5, 3};
    int tv_v [8] = '{3, 4, 5, 8, 16, 4, 3, 8};
    int tv_w [8] = '{1, 2, 3, 5, 1, 2, 1, 5};
    int tv_x [8] = '{8, 14, 16, 11, 15, 14, 8, 11};
    int tv_y [8] = '{2, 12, 3, 9, 0, 12, 2, 9};
    int gap  [7] = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0;
        u = '0; v = '0; w = '0; M = 32'd17; M_inv = 8'h0F;
        lit_en = 1'b0; lit_x = 0; lit_y = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single directed butterflies, each drained before the next.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, tv_md[i][0], tv_u[i], tv_v[i], tv_w[i], 1'b1, tv_x[i], tv_y[i]);
            idle(L + 1);
        end

        // Back-to-back alternating CT/GS.
        for (int i = 0; i < 8; i++)
            drive(1'b1, tv_md[i][0], tv_u[i], tv_v[i], tv_w[i], 1'b1, tv_x[i], tv_y[i]);
        idle(L + 1);

        // Gapped valid pattern.
        for (int i = 0; i < 7; i++)
            drive(gap[i][0], tv_md[i][0], tv_u[i], tv_v[i], tv_w[i], 1'b1, tv_x[i], tv_y[i]);
        idle(L + 1);

        // Reset with three butterflies in flight.
        for (int i = 0; i < 3; i++)
            drive(1'b1, tv_md[i][0], tv_u[i], tv_v[i], tv_w[i], 1'b0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(L + 2);

        // Random moduli, including the extremes, with random streams.
        for (int r = 0; r < 20; r++) begin
            @(negedge clk);
            if (r == 0)      M = 32'd3;
            else if (r == 1) M = 32'h3FFF_FFFF;
            else             M = ($urandom_range(1, (1 << 29) - 1) << 1) | 32'd1;
            M_inv = neg_inv8(longint'(M));
            for (int i = 0; i < 40; i++) begin
                drive(($urandom_range(0, 9) < 6), $urandom_range(0, 1) == 1,
                      int'($urandom % M), int'($urandom % M), int'($urandom % M), 1'b0, 0, 0);
            end
            idle(L + 1);
        end

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
